// File: rtl/cpc_vram_scheduler.sv
// cpc_vram_scheduler: 16-phase 1 us memory cycle sequencer.
// Shares one RAM port between CRTC video fetch and a Z80 slot.
module cpc_vram_scheduler #(
   parameter int RAM_LAT = 2
) (
   input  logic        CLOCK,
   input  logic        nRESET,
   output logic        crtc_clken,
   output logic        crtc_nclken,
   input  logic [13:0] crtc_ma,
   input  logic [4:0]  crtc_ra,
   input  logic        crtc_de,
   input  logic        vid_en,
   output logic [15:0] vid_data,
   output logic        vid_de,
   output logic        vid_valid,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [15:0] cpu_addr,
   input  logic [7:0]  cpu_dout,
   output logic [7:0]  cpu_din,
   output logic        cpu_ack,
   output logic        cpu_wait,
   output logic [15:0] ram_addr,
   output logic        ram_rd,
   output logic        ram_we,
   output logic [7:0]  ram_din,
   input  logic [7:0]  ram_dout
);

   localparam logic [3:0] PH_B0  = 4'(RAM_LAT);
   localparam logic [3:0] PH_B1  = 4'(4 + RAM_LAT);
   localparam logic [3:0] PH_CPU = 4'(8 + RAM_LAT);

   logic [3:0]  phase;
   logic [14:0] vbase;
   logic [14:0] vbase_q;
   logic        de_q;
   logic        vid_act;
   logic [7:0]  byte0_q;
   logic [15:0] addr_q;
   logic [7:0]  wdata_q;
   logic [7:0]  rdata_q;
   logic        rd_pend;
   logic        wr_ack;
   logic        granted;
   logic        fetch0;
   logic        fetch1;
   logic        grant;
   logic        rd_done;
   logic        unused_ok;

   // MA[11:10] and RA[4:3] do not take part in the video address
   assign unused_ok = ^{crtc_ma[11:10], crtc_ra[4:3]};

   assign vbase   = {crtc_ma[13:12], crtc_ra[2:0], crtc_ma[9:0]};
   assign fetch0  = nRESET && phase == 4'd0 && vid_en;
   assign fetch1  = nRESET && phase == 4'd4 && vid_act;
   assign grant   = nRESET && phase == 4'd8 && cpu_req;
   assign rd_done = nRESET && rd_pend && phase == PH_CPU;

   assign crtc_clken  = phase == 4'd15;
   assign crtc_nclken = phase == 4'd7;
   assign cpu_ack     = (nRESET && wr_ack) || rd_done;
   assign cpu_din     = rd_done ? ram_dout : rdata_q;
   assign cpu_wait    = nRESET && cpu_req && !granted;

   // RAM port mux: video byte 0, video byte 1, CPU slot, else hold
   always_comb begin
      ram_addr = addr_q;
      ram_din  = wdata_q;
      ram_rd   = 1'b0;
      ram_we   = 1'b0;
      if (fetch0) begin
         ram_addr = {vbase, 1'b0};
         ram_rd   = 1'b1;
      end else if (fetch1) begin
         ram_addr = {vbase_q, 1'b1};
         ram_rd   = 1'b1;
      end else if (grant) begin
         ram_addr = cpu_addr;
         ram_din  = cpu_dout;
         ram_we   = cpu_we;
         ram_rd   = !cpu_we;
      end
   end

   // Phase sequencer, video capture and CPU slot bookkeeping
   always_ff @(posedge CLOCK) begin
      if (!nRESET) begin
         phase     <= 4'd0;
         vbase_q   <= '0;
         de_q      <= 1'b0;
         vid_act   <= 1'b0;
         byte0_q   <= '0;
         vid_data  <= '0;
         vid_de    <= 1'b0;
         vid_valid <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         rdata_q   <= '0;
         rd_pend   <= 1'b0;
         wr_ack    <= 1'b0;
         granted   <= 1'b0;
      end else begin
         phase   <= phase + 4'd1;
         addr_q  <= ram_addr;
         wdata_q <= ram_din;
         rdata_q <= cpu_din;
         if (phase == 4'd0) begin
            vid_act <= vid_en;
            if (vid_en) begin
               vbase_q <= vbase;
               de_q    <= crtc_de;
            end
         end
         if (vid_act && phase == PH_B0)
            byte0_q <= ram_dout;
         vid_valid <= vid_act && phase == PH_B1;
         if (vid_act && phase == PH_B1) begin
            vid_data <= {ram_dout, byte0_q};
            vid_de   <= de_q;
         end
         wr_ack <= grant && cpu_we;
         if (grant && !cpu_we)
            rd_pend <= 1'b1;
         else if (rd_done)
            rd_pend <= 1'b0;
         if (grant)
            granted <= 1'b1;
         else if (cpu_ack)
            granted <= 1'b0;
      end
   end

endmodule

// File: tb/tb_cpc_vram_scheduler.sv
// tb_cpc_vram_scheduler: random stimulus, queue scoreboard.
// Model: phase = cycles since reset mod 16, plus a byte RAM image.
module tb_cpc_vram_scheduler;

   localparam int L      = 2;
   localparam int NTOT   = 3000;
   localparam int RST_AT = 1609;

   logic        CLOCK = 1'b0;
   logic        nRESET = 1'b0;
   logic        crtc_clken, crtc_nclken;
   logic [13:0] crtc_ma = '0;
   logic [4:0]  crtc_ra = '0;
   logic        crtc_de = 1'b0;
   logic        vid_en = 1'b0;
   logic [15:0] vid_data;
   logic        vid_de, vid_valid;
   logic        cpu_req = 1'b0;
   logic        cpu_we = 1'b0;
   logic [15:0] cpu_addr = '0;
   logic [7:0]  cpu_dout = '0;
   logic [7:0]  cpu_din;
   logic        cpu_ack, cpu_wait;
   logic [15:0] ram_addr;
   logic        ram_rd, ram_we;
   logic [7:0]  ram_din;
   logic [7:0]  ram_dout;

   always #5 CLOCK = ~CLOCK;

   cpc_vram_scheduler #(.RAM_LAT(L)) dut (
      .CLOCK(CLOCK), .nRESET(nRESET),
      .crtc_clken(crtc_clken), .crtc_nclken(crtc_nclken),
      .crtc_ma(crtc_ma), .crtc_ra(crtc_ra), .crtc_de(crtc_de),
      .vid_en(vid_en), .vid_data(vid_data), .vid_de(vid_de),
      .vid_valid(vid_valid), .cpu_req(cpu_req), .cpu_we(cpu_we),
      .cpu_addr(cpu_addr), .cpu_dout(cpu_dout), .cpu_din(cpu_din),
      .cpu_ack(cpu_ack), .cpu_wait(cpu_wait), .ram_addr(ram_addr),
      .ram_rd(ram_rd), .ram_we(ram_we), .ram_din(ram_din),
      .ram_dout(ram_dout)
   );

   typedef struct {
      int          cyc;
      logic        rd;
      logic        we;
      logic [15:0] addr;
      logic [7:0]  din;
   } strobe_t;
   typedef struct {
      int          cyc;
      logic [15:0] data;
      logic        de;
   } vid_t;
   typedef struct {
      int          cyc;
      logic        rd;
      logic [7:0]  din;
   } ack_t;

   strobe_t sq[$];
   vid_t    vq[$];
   ack_t    aq[$];

   logic [7:0] ram [65536];
   logic [7:0] ref_mem [65536];
   logic [7:0] pipe [L];

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   bit   mon_on = 0;
   bit   rst_chk = 0;
   bit   stopping = 0;
   logic wait_exp = 1'b0;

   bit          creq = 0;
   bit          granted = 0;
   logic        cwe = 1'b0;
   logic [15:0] caddr = '0;
   logic [7:0]  cdata = '0;
   int          gcyc = 0;
   int          ack_cyc = 0;

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (cyc %0d)",
                  name, act, exp, cyc);
      end
   endtask

   task automatic miss(input string name, input int ecyc);
      checks++;
      errors++;
      $display("FAIL %s: not seen, expected at cyc %0d (now %0d)",
               name, ecyc, cyc);
   endtask

   function automatic logic [15:0] vaddr(input logic [13:0] ma,
                                         input logic [4:0] ra,
                                         input int b);
      int m;
      int r;
      m = int'(ma);
      r = int'(ra);
      return 16'((m / 4096 % 4) * 16384 + (r % 8) * 2048
                 + (m % 1024) * 2 + b);
   endfunction

   function automatic logic [15:0] pick_addr();
      case ($urandom_range(0, 5))
         0: return 16'h1234;
         1: return 16'h4000;
         2: return 16'h00F0;
         3: return 16'hD00A;
         default: return 16'($urandom);
      endcase
   endfunction

   // RAM model: fixed read latency, random bus when not reading
   always @(posedge CLOCK) begin
      if (ram_we) ram[ram_addr] <= ram_din;
      pipe[0] <= ram_rd ? ram[ram_addr] : 8'($urandom);
      for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
   end
   assign ram_dout = pipe[L-1];

   // Monitor: per-cycle strobe checks and scoreboard pops
   always @(negedge CLOCK) begin : mon
      strobe_t s;
      vid_t    v;
      ack_t    a;
      int      ph;
      if (rst_chk) begin
         check("reset_outputs",
               {crtc_clken, crtc_nclken, vid_data, vid_de, vid_valid,
                cpu_din, cpu_ack, cpu_wait, ram_addr, ram_rd, ram_we,
                ram_din}, 64'd0);
      end else if (mon_on) begin
         ph = cyc % 16;
         check("crtc_clken", crtc_clken, ph == 15);
         check("crtc_nclken", crtc_nclken, ph == 7);
         check("cpu_wait", cpu_wait, wait_exp);
         while (sq.size() > 0 && sq[0].cyc < cyc) begin
            miss("ram_strobe", sq[0].cyc);
            void'(sq.pop_front());
         end
         while (vq.size() > 0 && vq[0].cyc < cyc) begin
            miss("vid_valid", vq[0].cyc);
            void'(vq.pop_front());
         end
         while (aq.size() > 0 && aq[0].cyc < cyc) begin
            miss("cpu_ack", aq[0].cyc);
            void'(aq.pop_front());
         end
         if (ram_rd || ram_we) begin
            if (sq.size() == 0) begin
               check("ram_strobe_unexpected", {ram_rd, ram_we}, 64'd0);
            end else begin
               s = sq.pop_front();
               check("strobe_cyc", cyc, s.cyc);
               check("ram_rd", ram_rd, s.rd);
               check("ram_we", ram_we, s.we);
               check("ram_addr", ram_addr, s.addr);
               if (s.we) check("ram_din", ram_din, s.din);
            end
         end
         if (vid_valid) begin
            if (vq.size() == 0) begin
               check("vid_valid_unexpected", vid_valid, 64'd0);
            end else begin
               v = vq.pop_front();
               check("vid_cyc", cyc, v.cyc);
               check("vid_data", vid_data, v.data);
               check("vid_de", vid_de, v.de);
            end
         end
         if (cpu_ack) begin
            if (aq.size() == 0) begin
               check("cpu_ack_unexpected", cpu_ack, 64'd0);
            end else begin
               a = aq.pop_front();
               check("ack_cyc", cyc, a.cyc);
               if (a.rd) check("cpu_din", cpu_din, a.din);
            end
         end
      end
   end

   task automatic do_reset();
      nRESET   = 1'b0;
      mon_on   = 0;
      cpu_req  = 1'b0;
      vid_en   = 1'b0;
      creq     = 0;
      granted  = 0;
      wait_exp = 1'b0;
      sq.delete();
      vq.delete();
      aq.delete();
      @(posedge CLOCK);
      #1;
      rst_chk = 1;
      repeat (2) begin
         @(posedge CLOCK);
         #1;
      end
      rst_chk = 0;
      nRESET  = 1'b1;
      mon_on  = 1;
      cyc     = 0;
   endtask

   task automatic start(input logic we, input logic [15:0] addr,
                        input logic [7:0] data);
      creq    = 1;
      granted = 0;
      cwe     = we;
      caddr   = addr;
      cdata   = data;
   endtask

   task automatic drive(input int tot);
      int          ph;
      logic [15:0] a0;
      logic [15:0] a1;
      ph       = cyc % 16;
      stopping = tot >= NTOT - 40;
      crtc_ma  = 14'($urandom);
      crtc_ra  = 5'($urandom);
      crtc_de  = 1'($urandom);
      vid_en   = 1'($urandom);
      if (ph == 0) begin
         vid_en = $urandom_range(0, 3) != 0;
         if (tot == 0) begin
            crtc_ma = 14'h3005;
            crtc_ra = 5'd2;
            crtc_de = 1'b1;
            vid_en  = 1'b1;
         end
         if (tot == 32 || stopping) vid_en = 1'b0;
         if (vid_en) begin
            a0 = vaddr(crtc_ma, crtc_ra, 0);
            a1 = vaddr(crtc_ma, crtc_ra, 1);
            sq.push_back('{cyc, 1'b1, 1'b0, a0, 8'h00});
            sq.push_back('{cyc + 4, 1'b1, 1'b0, a1, 8'h00});
            vq.push_back('{cyc + 5 + L, {ref_mem[a1], ref_mem[a0]},
                           crtc_de});
         end
      end
      if (creq && granted && cyc == ack_cyc + 1) begin
         creq    = 0;
         granted = 0;
      end else if (!creq && !stopping) begin
         if (tot == 9)
            start(1'b0, 16'h4000, 8'h00);
         else if (tot == 28)
            start(1'b1, 16'h1234, 8'hA5);
         else if (tot == 43)
            start(1'b0, 16'h1234, 8'h00);
         else if (tot == RST_AT - 6)
            start(1'b0, 16'($urandom), 8'h00);
         else if (tot >= 64 && !(tot >= RST_AT - 21 && tot <= RST_AT + 16)
                  && $urandom_range(0, 5) == 0)
            start(1'($urandom), pick_addr(), 8'($urandom));
      end
      if (creq && !granted && ph == 8) begin
         granted = 1;
         gcyc    = cyc;
         ack_cyc = cwe ? cyc + 1 : cyc + L;
         sq.push_back('{cyc, !cwe, cwe, caddr, cdata});
         aq.push_back('{ack_cyc, !cwe, ref_mem[caddr]});
         if (cwe) ref_mem[caddr] = cdata;
      end
      cpu_req = creq;
      if (creq) begin
         cpu_we   = cwe;
         cpu_addr = caddr;
         cpu_dout = cdata;
      end else begin
         cpu_we   = 1'($urandom);
         cpu_addr = 16'($urandom);
         cpu_dout = 8'($urandom);
      end
      wait_exp = creq && (!granted || cyc == gcyc);
   endtask

   initial begin
      for (int i = 0; i < 65536; i++) begin
         ram[i]     = 8'(i);
         ref_mem[i] = 8'(i);
      end
      do_reset();
      for (int tot = 0; tot < NTOT; tot++) begin
         if (tot == RST_AT) do_reset();
         drive(tot);
         @(posedge CLOCK);
         #1;
         cyc++;
      end
      mon_on = 0;
      foreach (sq[i]) miss("ram_strobe_left", sq[i].cyc);
      foreach (vq[i]) miss("vid_valid_left", vq[i].cyc);
      foreach (aq[i]) miss("cpu_ack_left", aq[i].cyc);
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
